// File: rtl/dcache_wt_mem.sv
// Direct-mapped, write-through, write-no-allocate MEM-stage data cache with word-wide refill.
// Optional hit/miss performance counters are enabled with `define DCACHE_PERF_EN.
module dcache_wt_mem #(
  parameter int SET_LOG  = 4,
  parameter int LINE_LOG = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  load_type,
  input  logic [3:0]  cache_write_en,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_req,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_be,
  input  logic        mem_wr_ack
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = 30 - SET_LOG - LINE_LOG;
  localparam int LINES = 1 << SET_LOG;
  localparam int WORDS = 1 << LINE_LOG;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  state_e                state_q, state_d;
  logic [LINE_LOG-1:0]   beat_q, beat_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic                  store_done_q, store_done_d;
  logic [31:0]           done_addr_q;
  logic [3:0]            done_be_q;
  logic [TAG_W-1:0]      tag_q [LINES];
  logic [31:0]           data_q [LINES*WORDS];

  logic [LINE_LOG-1:0]   a_word;
  logic [SET_LOG-1:0]    a_idx;
  logic [TAG_W-1:0]      a_tag;
  logic                  is_store, is_load, hit, retired, miss_raw;
  logic                  arr_we, tag_we;
  logic [SET_LOG+LINE_LOG-1:0] arr_waddr;
  logic [31:0]           arr_wdata;
  logic [3:0]            arr_wbe;
  logic [31:0]           word_sel;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign a_word   = addr[LINE_LOG+1:2];
  assign a_idx    = addr[SET_LOG+LINE_LOG+1:LINE_LOG+2];
  assign a_tag    = addr[31:SET_LOG+LINE_LOG+2];
  assign is_store = |cache_write_en;
  assign is_load  = !is_store && (load_type >= 3'd1) && (load_type <= 3'd5);
  assign hit      = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  // A store that was already acknowledged stays retired until addr or enables change.
  assign retired  = store_done_q && (addr == done_addr_q) && (cache_write_en == done_be_q);

  assign mem_rd_addr = {a_tag, a_idx, beat_q, 2'b00};
  assign mem_wr_addr = {addr[31:2], 2'b00};
  assign mem_wr_data = wr_data;
  assign mem_wr_be   = cache_write_en;
  assign miss        = miss_raw & rst_n;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    valid_d      = valid_q;
    store_done_d = store_done_q;
    miss_raw     = 1'b0;
    mem_rd_req   = 1'b0;
    mem_wr_req   = 1'b0;
    arr_we       = 1'b0;
    tag_we       = 1'b0;
    arr_waddr    = {a_idx, a_word};
    arr_wdata    = wr_data;
    arr_wbe      = cache_write_en;
    case (state_q)
      IDLE: begin
        store_done_d = retired;
        if (is_store) begin
          if (!retired) begin
            miss_raw = 1'b1;
            state_d  = WRITE;
            arr_we   = hit;
          end
        end else if (is_load && !hit) begin
          miss_raw = 1'b1;
          state_d  = REFILL;
          beat_d   = '0;
        end
      end
      REFILL: begin
        mem_rd_req = 1'b1;
        miss_raw   = 1'b1;
        if (mem_rd_valid) begin
          arr_we    = 1'b1;
          arr_waddr = {a_idx, beat_q};
          arr_wdata = mem_rd_data;
          arr_wbe   = 4'hF;
          beat_d    = beat_q + 1'b1;
          if (&beat_q) begin
            valid_d[a_idx] = 1'b1;
            tag_we         = 1'b1;
            state_d        = IDLE;
            beat_d         = '0;
          end
        end
      end
      WRITE: begin
        mem_wr_req = 1'b1;
        miss_raw   = 1'b1;
        if (mem_wr_ack) begin
          state_d      = IDLE;
          store_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      valid_q      <= '0;
      store_done_q <= 1'b0;
      done_addr_q  <= '0;
      done_be_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      valid_q      <= valid_d;
      store_done_q <= store_done_d;
      if (state_q == WRITE && mem_wr_ack) begin
        done_addr_q <= addr;
        done_be_q   <= cache_write_en;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int b = 0; b < 4; b++) begin
        if (arr_wbe[b]) data_q[arr_waddr][8*b +: 8] <= arr_wdata[8*b +: 8];
      end
    end
    if (tag_we) tag_q[a_idx] <= a_tag;
  end

  assign word_sel = data_q[{a_idx, a_word}];
  assign half_sel = addr[1] ? word_sel[31:16] : word_sel[15:0];

  always_comb begin
    byte_sel = word_sel[7:0];
    case (addr[1:0])
      2'd1:    byte_sel = word_sel[15:8];
      2'd2:    byte_sel = word_sel[23:16];
      2'd3:    byte_sel = word_sel[31:24];
      default: byte_sel = word_sel[7:0];
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (is_load) begin
      case (load_type)
        3'd1:    rd_data = {{24{byte_sel[7]}}, byte_sel};
        3'd2:    rd_data = {{16{half_sel[15]}}, half_sel};
        3'd3:    rd_data = word_sel;
        3'd4:    rd_data = {24'd0, byte_sel};
        3'd5:    rd_data = {16'd0, half_sel};
        default: rd_data = '0;
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        miss_prev_q;

  // A hit right after a miss cycle is the tail of a refill, not a first-presentation hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      miss_prev_q <= 1'b0;
    end else begin
      miss_prev_q <= miss_raw;
      if (state_q == IDLE && is_load && hit && !miss_prev_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == IDLE && state_d == REFILL) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_wt_mem.sv
// Bench for dcache_wt_mem: directed scenarios plus randomized traffic against a
// residency-set and backing-memory reference model.
module tb_dcache_wt_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, wr_data = '0;
  logic [2:0]  load_type = '0;
  logic [3:0]  cache_write_en = '0;
  logic [31:0] rd_data;
  logic        miss, mem_rd_req, mem_wr_req;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        mem_rd_valid = 1'b0, mem_wr_ack = 1'b0;
  logic [31:0] mem_rd_data = '0;
`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dcache_wt_mem dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data),
    .load_type(load_type), .cache_write_en(cache_write_en),
    .rd_data(rd_data), .miss(miss),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_wr_ack(mem_wr_ack)
`ifdef DCACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Backing memory, keyed by word address; untouched words read a fixed pattern.
  logic [31:0] mem [bit [29:0]];

  function automatic logic [31:0] mem_get(input bit [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[13:0], 2'b10, w[15:0]} ^ 32'hC3A5_5A3C;
  endfunction

  // Reference cache: which line (tag) each set holds; contents always equal memory.
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  function automatic bit resident(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  function automatic logic [31:0] expect_load(input logic [31:0] a, input logic [2:0] lt);
    logic [31:0] w, b, h;
    w = mem_get(a[31:2]);
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (lt)
      3'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd2: return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd3: return w;
      3'd4: return b;
      3'd5: return h;
      default: return 32'h0;
    endcase
  endfunction

  // Memory responder: read data / write acks are decided at the falling edge.
  bit          rd_rand = 1'b0, stray_en = 1'b0;
  int          wr_cycles = 1, wr_wait = 0;
  logic [31:0] rd_log [$];
  logic [31:0] wa_log [$], wd_log [$];
  logic [3:0]  wb_log [$];

  always @(negedge clk) begin
    logic [31:0] w;
    if (mem_rd_req) begin
      mem_rd_valid = rd_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      mem_rd_data  = mem_get(mem_rd_addr[31:2]);
      if (mem_rd_valid) rd_log.push_back(mem_rd_addr);
    end else begin
      mem_rd_valid = stray_en && ($urandom_range(0, 3) == 0);
      mem_rd_data  = $urandom;
    end
    if (mem_wr_req) begin
      wr_wait++;
      if (wr_wait >= wr_cycles) begin
        mem_wr_ack = 1'b1;
        wr_wait = 0;
        wa_log.push_back(mem_wr_addr);
        wd_log.push_back(mem_wr_data);
        wb_log.push_back(mem_wr_be);
        w = mem_get(mem_wr_addr[31:2]);
        for (int b = 0; b < 4; b++) if (mem_wr_be[b]) w[8*b +: 8] = mem_wr_data[8*b +: 8];
        mem[mem_wr_addr[31:2]] = w;
      end else begin
        mem_wr_ack = 1'b0;
      end
    end else begin
      wr_wait = 0;
      mem_wr_ack = stray_en && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [2:0] lt,
                         output logic [31:0] data, output int mcyc);
    @(posedge clk); #1;
    addr = a; load_type = lt; cache_write_en = 4'h0; wr_data = $urandom;
    mcyc = 0;
    @(negedge clk);
    while (miss === 1'b1 && mcyc <= 200) begin
      mcyc++;
      @(negedge clk);
    end
    data = rd_data;
    if (mcyc > 200) begin
      total++; bad++;
      $display("[TB] FAIL load_timeout addr=%h got miss stuck, want release", a);
    end
    if (lt >= 3'd1 && lt <= 3'd5) begin
      m_valid[a[7:4]] = 1'b1;
      m_tag[a[7:4]] = a[31:8];
    end
    @(posedge clk); #1;
    load_type = 3'd0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          input logic [2:0] lt, output int mcyc, output logic [31:0] rd_at_done);
    @(posedge clk); #1;
    addr = a; load_type = lt; cache_write_en = be; wr_data = d;
    mcyc = 0;
    @(negedge clk);
    while (miss === 1'b1 && mcyc <= 200) begin
      mcyc++;
      @(negedge clk);
    end
    rd_at_done = rd_data;
    if (mcyc > 200) begin
      total++; bad++;
      $display("[TB] FAIL store_timeout addr=%h got miss stuck, want release", a);
    end
    @(posedge clk); #1;
    cache_write_en = 4'h0; load_type = 3'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (miss !== 1'b0) begin bad++; $display("[TB] FAIL reset_miss got=%b want=0", miss); end
    total++; if (mem_rd_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_req got=%b want=0", mem_rd_req); end
    total++; if (mem_wr_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_req got=%b want=0", mem_wr_req); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rd_data got=%h want=0", rd_data); end
  endtask

  task automatic test_cold_load();
    logic [31:0] d; int m, base;
    mem[30'h40] = 32'h11; mem[30'h41] = 32'h22; mem[30'h42] = 32'h33; mem[30'h43] = 32'h44;
    base = rd_log.size();
    do_load(32'h100, 3'd3, d, m);
    total++; if (m != 5) begin bad++; $display("[TB] FAIL cold_miss_cycles got=%0d want=5", m); end
    total++; if (rd_log.size() - base != 4) begin bad++; $display("[TB] FAIL cold_read_count got=%0d want=4", rd_log.size() - base); end
    for (int i = 0; i < 4 && base + i < rd_log.size(); i++) begin
      total++;
      if (rd_log[base+i] !== 32'h100 + 32'(4*i)) begin
        bad++; $display("[TB] FAIL cold_read_addr%0d got=%h want=%h", i, rd_log[base+i], 32'h100 + 32'(4*i));
      end
    end
    total++; if (d !== 32'h11) begin bad++; $display("[TB] FAIL cold_data got=%h want=00000011", d); end
    do_load(32'h108, 3'd3, d, m);
    total++; if (m != 0) begin bad++; $display("[TB] FAIL rehit_miss_cycles got=%0d want=0", m); end
    total++; if (d !== 32'h33) begin bad++; $display("[TB] FAIL rehit_data got=%h want=00000033", d); end
  endtask

  task automatic test_extension();
    logic [31:0] d; int m;
    mem[30'h80] = 32'h80FF_7F01;
    do_load(32'h202, 3'd1, d, m);
    total++; if (m != 5) begin bad++; $display("[TB] FAIL ext_refill got=%0d want=5", m); end
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL ext_lb got=%h want=ffffffff", d); end
    do_load(32'h203, 3'd4, d, m);
    total++; if (d !== 32'h0000_0080 || m != 0) begin bad++; $display("[TB] FAIL ext_lbu got=%h/%0d want=00000080/0", d, m); end
    do_load(32'h202, 3'd2, d, m);
    total++; if (d !== 32'hFFFF_80FF || m != 0) begin bad++; $display("[TB] FAIL ext_lh got=%h/%0d want=ffff80ff/0", d, m); end
    do_load(32'h200, 3'd5, d, m);
    total++; if (d !== 32'h0000_7F01 || m != 0) begin bad++; $display("[TB] FAIL ext_lhu got=%h/%0d want=00007f01/0", d, m); end
  endtask

  task automatic test_store_hit();
    logic [31:0] d, r; int m, wbase;
    wr_cycles = 3;
    wbase = wa_log.size();
    do_store(32'h200, 4'b0010, 32'h0000_AB00, 3'd0, m, r);
    total++; if (m != 4) begin bad++; $display("[TB] FAIL sthit_miss_cycles got=%0d want=4", m); end
    total++; if (wa_log.size() - wbase != 1) begin bad++; $display("[TB] FAIL sthit_write_count got=%0d want=1", wa_log.size() - wbase); end
    if (wa_log.size() > wbase) begin
      total++;
      if (wa_log[wbase] !== 32'h200 || wb_log[wbase] !== 4'b0010 || wd_log[wbase] !== 32'h0000_AB00) begin
        bad++; $display("[TB] FAIL sthit_write got=%h/%b/%h want=00000200/0010/0000ab00", wa_log[wbase], wb_log[wbase], wd_log[wbase]);
      end
    end
    total++; if (r !== 32'h0) begin bad++; $display("[TB] FAIL sthit_rd_data got=%h want=0", r); end
    do_load(32'h200, 3'd3, d, m);
    total++; if (d !== 32'h80FF_AB01 || m != 0) begin bad++; $display("[TB] FAIL sthit_reload got=%h/%0d want=80ffab01/0", d, m); end
  endtask

  task automatic test_store_miss();
    logic [31:0] d, r; int m, wbase, rbase;
    wr_cycles = 1;
    wbase = wa_log.size(); rbase = rd_log.size();
    do_store(32'h400, 4'hF, 32'hDEAD_BEEF, 3'd0, m, r);
    total++; if (m != 2) begin bad++; $display("[TB] FAIL stmiss_miss_cycles got=%0d want=2", m); end
    total++; if (wa_log.size() - wbase != 1) begin bad++; $display("[TB] FAIL stmiss_write_count got=%0d want=1", wa_log.size() - wbase); end
    total++; if (rd_log.size() != rbase) begin bad++; $display("[TB] FAIL stmiss_no_refill got=%0d want=0", rd_log.size() - rbase); end
    do_load(32'h400, 3'd3, d, m);
    total++; if (m != 5) begin bad++; $display("[TB] FAIL stmiss_load_miss got=%0d want=5", m); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL stmiss_load_data got=%h want=deadbeef", d); end
  endtask

  task automatic test_conflict();
    logic [31:0] d; int m;
    do_load(32'h100, 3'd3, d, m);
    total++; if (m != 5 || d !== 32'h11) begin bad++; $display("[TB] FAIL conflict_first got=%0d/%h want=5/00000011", m, d); end
    do_load(32'h200, 3'd3, d, m);
    total++; if (m != 5 || d !== 32'h80FF_AB01) begin bad++; $display("[TB] FAIL conflict_second got=%0d/%h want=5/80ffab01", m, d); end
    do_load(32'h100, 3'd3, d, m);
    total++; if (m != 5) begin bad++; $display("[TB] FAIL conflict_third got=%0d want=5", m); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d; int m, base, guard;
    do_load(32'h200, 3'd3, d, m);
    @(posedge clk); #1;
    addr = 32'h100; load_type = 3'd3;
    base = rd_log.size(); guard = 0;
    while (rd_log.size() < base + 2 && guard < 50) begin @(posedge clk); guard++; end
    total++; if (guard >= 50) begin bad++; $display("[TB] FAIL rst_wait_beats got=%0d want=2", rd_log.size() - base); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_rd_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd_req got=%b want=0", mem_rd_req); end
    total++; if (miss !== 1'b0) begin bad++; $display("[TB] FAIL rst_miss got=%b want=0", miss); end
    load_type = 3'd0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    base = rd_log.size();
    do_load(32'h100, 3'd3, d, m);
    total++; if (m != 5 || d !== 32'h11) begin bad++; $display("[TB] FAIL rst_reload got=%0d/%h want=5/00000011", m, d); end
    total++; if (rd_log.size() - base != 4 || rd_log[base] !== 32'h100) begin bad++; $display("[TB] FAIL rst_full_refill got=%0d want=4 from 00000100", rd_log.size() - base); end
  endtask

  task automatic test_random();
    logic [3:0]  be_tab [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [31:0] a, d, r, e;
    logic [2:0]  lt;
    logic [3:0]  be;
    int m, rbase, wbase, wc;
    bit res, ok;
    rd_rand = 1'b1; stray_en = 1'b1;
    repeat (150) begin
      a = 32'($urandom_range(0, 1023));
      lt = 3'($urandom_range(0, 7));
      rbase = rd_log.size(); wbase = wa_log.size();
      if ($urandom_range(0, 3) == 0) begin
        be = be_tab[$urandom_range(0, 6)];
        wc = $urandom_range(1, 3); wr_cycles = wc;
        d = $urandom;
        do_store(a, be, d, lt, m, r);
        total++; if (m != 1 + wc) begin bad++; $display("[TB] FAIL rnd_store_cycles addr=%h got=%0d want=%0d", a, m, 1 + wc); end
        ok = (wa_log.size() - wbase == 1) && (rd_log.size() == rbase);
        if (ok) ok = (wa_log[wbase] === {a[31:2], 2'b00}) && (wb_log[wbase] === be) && (wd_log[wbase] === d);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rnd_store_traffic addr=%h be=%b got writes=%0d reads=%0d want one write", a, be, wa_log.size() - wbase, rd_log.size() - rbase); end
        total++; if (r !== 32'h0) begin bad++; $display("[TB] FAIL rnd_store_rd_data got=%h want=0", r); end
      end else begin
        res = resident(a) || !(lt >= 3'd1 && lt <= 3'd5);
        e = expect_load(a, lt);
        do_load(a, lt, d, m);
        total++; if (d !== e) begin bad++; $display("[TB] FAIL rnd_load_data addr=%h type=%0d got=%h want=%h", a, lt, d, e); end
        total++; if ((m != 0) != !res) begin bad++; $display("[TB] FAIL rnd_load_miss addr=%h type=%0d got=%0d cycles want miss=%0d", a, lt, m, !res); end
        ok = res ? (rd_log.size() == rbase) : (rd_log.size() - rbase == 4);
        for (int i = 0; i < 4 && ok && !res; i++) ok = (rd_log[rbase+i] === {a[31:4], 4'h0} + 32'(4*i));
        total++; if (!ok) begin bad++; $display("[TB] FAIL rnd_load_reads addr=%h got=%0d reads want=%0d", a, rd_log.size() - rbase, res ? 0 : 4); end
      end
    end
    rd_rand = 1'b0; stray_en = 1'b0;
  endtask

  initial begin
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    test_reset();
    test_cold_load();
    test_extension();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_refill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
